// File: rtl/photo_pkg.sv
// Shared definitions for the photo capture write path: FSM state encoding
// and default frame geometry (320x240 RGB444).
package photo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  localparam int PHOTO_FRAME_W = 320;
  localparam int PHOTO_FRAME_H = 240;
  localparam int PHOTO_DEPTH   = PHOTO_FRAME_W * PHOTO_FRAME_H;
  localparam int PHOTO_PIX_W   = 12;

endpackage

// File: rtl/photo_decim.sv
// Column/row position tracking and the x/y decimation keep decision.
// Both counters saturate. A line end (line_valid falling) restarts the
// column and advances the row.
module photo_decim
  import photo_pkg::*;
#(
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int SCALE_LOG2 = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic line_valid_i,
  input  logic pix_valid_i,
  output logic keep_o
);

  localparam logic [X_W-1:0] X_MASK = X_W'((1 << SCALE_LOG2) - 1);
  localparam logic [Y_W-1:0] Y_MASK = Y_W'((1 << SCALE_LOG2) - 1);
  localparam logic [X_W-1:0] X_MAX  = '1;
  localparam logic [Y_W-1:0] Y_MAX  = '1;

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           lv_q, lv_d;

  assign keep_o = pix_valid_i && line_valid_i &&
                  ((x_q & X_MASK) == '0) && ((y_q & Y_MASK) == '0);

  // Next position: clear, line end, or advance on every valid pixel.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    lv_d = line_valid_i;
    if (clear_i) begin
      x_d  = '0;
      y_d  = '0;
      lv_d = 1'b0;
    end else if (lv_q && !line_valid_i) begin
      x_d = '0;
      if (y_q != Y_MAX) y_d = y_q + Y_W'(1);
    end else if (line_valid_i && pix_valid_i) begin
      if (x_q != X_MAX) x_d = x_q + X_W'(1);
    end
  end

  // Position registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q  <= '0;
      y_q  <= '0;
      lv_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      lv_q <= lv_d;
    end
  end

endmodule

// File: rtl/photo_capture_wr.sv
// Frame-buffer write side of photo capture. Inside the wen window, pixels
// surviving decimation are written sequentially from address 0; writes stop
// once DEPTH words are stored and further kept pixels raise a sticky overflow.
// Optional line/drop statistics are built when PHOTO_CAPTURE_STATS_EN is defined.
//
// state      | meaning
// IDLE       | waiting for wen rising edge; counters hold for readback
// ARMED      | window open, waiting for the first line_valid rising edge
// CAPTURE    | writing kept pixels
// FULL       | buffer full; kept pixels are dropped until wen falls
module photo_capture_wr
  import photo_pkg::*;
#(
  parameter int PIX_W      = PHOTO_PIX_W,
  parameter int ADDR_W     = 17,
  parameter int DEPTH      = PHOTO_DEPTH,
  parameter int SCALE_LOG2 = 1,
  parameter int X_W        = 11,
  parameter int Y_W        = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wen_i,
  input  logic              line_valid_i,
  input  logic              pix_valid_i,
  input  logic [PIX_W-1:0]  pix_data_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [PIX_W-1:0]  mem_wdata_o,
  output logic [ADDR_W-1:0] wr_count_o,
  output logic              busy_o,
  output logic              overflow_o
`ifdef PHOTO_CAPTURE_STATS_EN
  ,
  output logic [Y_W-1:0]    line_count_o,
  output logic [15:0]       drop_count_o
`endif
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t            state_q, state_d;
  logic              wen_d_q, lv_d_q;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [ADDR_W-1:0] wr_count_q, wr_count_d;
  logic              overflow_q, overflow_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic wen_rise, lv_rise, clear, active, keep;

  assign wen_rise = wen_i && !wen_d_q;
  assign lv_rise  = line_valid_i && !lv_d_q;
  assign clear    = (state_q == ST_IDLE) && wen_rise;
  assign addr_inc = addr_q + ADDR_W'(1);
  // Pixels count only while the window is open and capture has begun;
  // the ARMED cycle that sees the line start already counts.
  assign active   = wen_i && ((state_q == ST_CAPTURE) || (state_q == ST_FULL) ||
                              ((state_q == ST_ARMED) && lv_rise));

  photo_decim #(
    .X_W        (X_W),
    .Y_W        (Y_W),
    .SCALE_LOG2 (SCALE_LOG2)
  ) u_decim (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (clear),
    .line_valid_i (line_valid_i && active),
    .pix_valid_i  (pix_valid_i && active),
    .keep_o       (keep)
  );

  // Next-state, address and write-port decisions.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_count_d  = wr_count_q;
    overflow_d  = overflow_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (wen_rise) begin
          addr_d     = '0;
          wr_count_d = '0;
          overflow_d = 1'b0;
          state_d    = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!wen_i)       state_d = ST_IDLE;
        else if (lv_rise) state_d = ST_CAPTURE;
      end
      ST_CAPTURE, ST_FULL: begin
        if (!wen_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (active && keep) begin
      if (addr_q != DEPTH_A) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = pix_data_i;
        addr_d      = addr_inc;
        wr_count_d  = addr_inc;
        if (addr_inc == DEPTH_A) state_d = ST_FULL;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State and write-port registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      wen_d_q     <= 1'b0;
      lv_d_q      <= 1'b0;
      addr_q      <= '0;
      wr_count_q  <= '0;
      overflow_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wen_d_q     <= wen_i;
      lv_d_q      <= line_valid_i;
      addr_q      <= addr_d;
      wr_count_q  <= wr_count_d;
      overflow_q  <= overflow_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wr_count_o  = wr_count_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);

`ifdef PHOTO_CAPTURE_STATS_EN
  logic [Y_W-1:0] line_count_q;
  logic [15:0]    drop_count_q;
  logic           line_end;

  assign line_end = wen_i && lv_d_q && !line_valid_i &&
                    ((state_q == ST_CAPTURE) || (state_q == ST_FULL));

  // Completed-line and full-buffer drop counters, both saturating.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear) begin
      line_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      if (line_end && (line_count_q != '1))
        line_count_q <= line_count_q + Y_W'(1);
      if (active && keep && (addr_q == DEPTH_A) && (drop_count_q != 16'hFFFF))
        drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign line_count_o = line_count_q;
  assign drop_count_o = drop_count_q;
`else
  // Statistics not built: no extra ports or counters.
`endif

endmodule
